// File: rtl/painel_pkg.sv
// Shared definitions for the panel scroll sequencer.
// Provides the shift-register mode encodings, the FSM state encoding,
// the default register width and the width of the step counter output.
package painel_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned PASSO_W   = 5;

  // Mode-select encoding {ch1,ch0} understood by the universal shift register
  localparam logic [1:0] MODO_HOLD  = 2'b00;
  localparam logic [1:0] MODO_DIR   = 2'b01;
  localparam logic [1:0] MODO_ESQ   = 2'b10;
  localparam logic [1:0] MODO_CARGA = 2'b11;

  // Sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CARGA   = 2'd1;
  localparam logic [1:0] ST_ESPERA  = 2'd2;
  localparam logic [1:0] ST_DESLOCA = 2'd3;

  // Shift mode for a latched direction (1 = right, 0 = left)
  function automatic logic [1:0] modo_desloca(input logic dir);
    return dir ? MODO_DIR : MODO_ESQ;
  endfunction

endpackage

// File: rtl/painel_divisor_passo.sv
// Step-period counter for the panel scroll sequencer.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   load_i        - clear the counter and latch a new period from velocidade_i
//   en_i          - advance the counter by one
//   velocidade_i  - speed select; period P = PRESC_BASE << (3 - velocidade_i)
//   term_o        - registered flag, high while the counter equals P-2
module painel_divisor_passo
  import painel_pkg::*;
#(
  parameter int unsigned PRESC_BASE = 4,
  parameter int unsigned CNT_W      = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [1:0] velocidade_i,
  output logic       term_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic             term_q, term_d;

  // Next counter/period; the terminal flag is computed from the next values
  // so it can be presented as a register in the same cycle the count hits P-2.
  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (load_i) begin
      cnt_d = '0;
      per_d = CNT_W'(PRESC_BASE) << (2'd3 - velocidade_i);
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    term_d = (cnt_d == (per_d - CNT_W'(2)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      per_q  <= CNT_W'(PRESC_BASE);
      term_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      term_q <= term_d;
    end
  end

  assign term_o = term_q;

endmodule

// File: rtl/painel_scroll_ctrl.sv
// Scroll sequencer for the panel's 16-bit universal shift register.
// Loads the message once, then issues one shift strobe per step period,
// left or right, for one rotation or continuously until stopped.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   iniciar         - start request (acted on only when idle)
//   parar           - stop request, overrides iniciar
//   direcao         - 0 shift left, 1 shift right (latched at start)
//   velocidade      - speed select (latched on every wait-phase entry)
//   continuo        - repeat rotations until parar
//   ch0, ch1        - registered mode select to the shift register
//   ativo           - high whenever not idle
//   passo           - shifts completed in the current rotation
//   fim_ciclo       - one-cycle pulse on the last shift of a rotation
module painel_scroll_ctrl
  import painel_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned PRESC_BASE = 4,
  parameter int unsigned CNT_W      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               iniciar,
  input  logic               parar,
  input  logic               direcao,
  input  logic [1:0]         velocidade,
  input  logic               continuo,
  output logic               ch0,
  output logic               ch1,
  output logic               ativo,
  output logic [PASSO_W-1:0] passo,
  output logic               fim_ciclo
);

  localparam logic [PASSO_W-1:0] PASSO_MAX = PASSO_W'(WIDTH);
  localparam logic [PASSO_W-1:0] PASSO_PEN = PASSO_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               ativo_q, ativo_d;
  logic [PASSO_W-1:0] passo_q, passo_d;
  logic               fim_q, fim_d;
  logic               dir_q, dir_d;
  logic               term;
  logic               load_per;

  // Period is re-latched and the counter cleared on every entry to ESPERA
  assign load_per = (state_d == ST_ESPERA) && (state_q != ST_ESPERA);

  painel_divisor_passo #(
    .PRESC_BASE (PRESC_BASE),
    .CNT_W      (CNT_W)
  ) u_div (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load_per),
    .en_i         (state_q == ST_ESPERA),
    .velocidade_i (velocidade),
    .term_o       (term)
  );

  // Next state and next registered outputs; outputs track the state entered
  always_comb begin
    state_d = state_q;
    mode_d  = MODO_HOLD;
    passo_d = passo_q;
    fim_d   = 1'b0;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (iniciar && !parar) begin
          state_d = ST_CARGA;
          mode_d  = MODO_CARGA;
          dir_d   = direcao;
          passo_d = '0;
        end
      end
      ST_CARGA: begin
        state_d = parar ? ST_IDLE : ST_ESPERA;
      end
      ST_ESPERA: begin
        if (parar) begin
          state_d = ST_IDLE;
        end else if (term) begin
          state_d = ST_DESLOCA;
          mode_d  = modo_desloca(dir_q);
          passo_d = passo_q + PASSO_W'(1);
          fim_d   = (passo_q == PASSO_PEN);
        end
      end
      ST_DESLOCA: begin
        if (parar) begin
          state_d = ST_IDLE;
        end else if (passo_q == PASSO_MAX) begin
          if (continuo) begin
            state_d = ST_ESPERA;
            passo_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_ESPERA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ativo_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODO_HOLD;
      ativo_q <= 1'b0;
      passo_q <= '0;
      fim_q   <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      ativo_q <= ativo_d;
      passo_q <= passo_d;
      fim_q   <= fim_d;
      dir_q   <= dir_d;
    end
  end

  assign ch0       = mode_q[0];
  assign ch1       = mode_q[1];
  assign ativo     = ativo_q;
  assign passo     = passo_q;
  assign fim_ciclo = fim_q;

endmodule
